// File: rtl/pulse_stretch_pkg.sv
// Shared types and helpers for the pulse stretcher.
// Retrigger mode is selected with PULSE_STRETCHER_RETRIGGER_EN.
package pulse_stretch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    function automatic int timer_width(input int high_cycles,
                                       input int gap_cycles);
        int m;
        m = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pulse_stretch_timer.sv
// Loadable down-counter shared by the HIGH and GAP intervals.
// Holds at zero; load wins over enable.
module pulse_stretch_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         enable,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches event pulses into fixed high intervals plus low gaps, queueing
// overlapping events. PULSE_STRETCHER_RETRIGGER_EN extends HIGH instead.
module pulse_stretcher
    import pulse_stretch_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int QUEUE_DEPTH = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             pulse_in,
    output logic                             level_out,
    output logic                             busy,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0] pending,
    output logic                             overflow
);

    localparam int TW = timer_width(HIGH_CYCLES, GAP_CYCLES);
    localparam int PW = $clog2(QUEUE_DEPTH + 1);

    localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 1);
    localparam logic [PW-1:0] PEND_MAX  = PW'(QUEUE_DEPTH);

    state_t        state;
    state_t        state_n;
    logic          tmr_load;
    logic [TW-1:0] tmr_value;
    logic          tmr_en;
    logic          tmr_zero;
    logic          pend_inc;
    logic          pend_dec;

    pulse_stretch_timer #(
        .W(TW)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (tmr_load),
        .load_value(tmr_value),
        .enable    (tmr_en),
        .zero      (tmr_zero)
    );

    always_comb begin
        state_n   = state;
        tmr_load  = 1'b0;
        tmr_value = HIGH_LOAD;
        tmr_en    = 1'b0;
        pend_inc  = 1'b0;
        pend_dec  = 1'b0;
        unique case (state)
            IDLE: begin
                if (pulse_in) begin
                    state_n  = HIGH;
                    tmr_load = 1'b1;
                end
            end
            HIGH: begin
                tmr_en = 1'b1;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
                if (pulse_in) begin
                    tmr_load = 1'b1;
                end else if (tmr_zero) begin
                    state_n   = GAP;
                    tmr_load  = 1'b1;
                    tmr_value = GAP_LOAD;
                end
`else
                pend_inc = pulse_in;
                if (tmr_zero) begin
                    state_n   = GAP;
                    tmr_load  = 1'b1;
                    tmr_value = GAP_LOAD;
                end
`endif
            end
            GAP: begin
                tmr_en   = 1'b1;
                pend_inc = pulse_in;
                if (tmr_zero) begin
                    if (pending != '0) begin
                        state_n  = HIGH;
                        tmr_load = 1'b1;
                        pend_dec = 1'b1;
                    end else if (pulse_in) begin
                        // the pulse starts the interval itself
                        state_n  = HIGH;
                        tmr_load = 1'b1;
                        pend_inc = 1'b0;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            level_out <= 1'b0;
            busy      <= 1'b0;
            pending   <= '0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_n;
            level_out <= (state_n == HIGH);
            busy      <= (state_n != IDLE);
            if (pend_inc && !pend_dec) begin
                if (pending == PEND_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    pending <= pending + 1'b1;
                end
            end else if (pend_dec && !pend_inc) begin
                pending <= pending - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: an interval-schedule model predicts
// each cycle's outputs; a monitor pops and compares them.
module tb_pulse_stretcher;

    localparam int H  = 4;
    localparam int G  = 2;
    localparam int Q  = 3;
    localparam int PW = $clog2(Q + 1);

    typedef struct {
        int cyc;
        bit lvl;
        bit bsy;
        int pnd;
        bit ovf;
    } exp_t;

    logic          clk;
    logic          reset;
    logic          pulse_in;
    logic          level_out;
    logic          busy;
    logic [PW-1:0] pending;
    logic          overflow;

    int   checks;
    int   errors;
    int   t;
    bit   run;
    exp_t exp_q[$];

    // accepted events: start cycle, last high cycle, accept edge
    int st[$];
    int he[$];
    int ac[$];
    bit m_ovf;

    pulse_stretcher #(
        .HIGH_CYCLES(H),
        .GAP_CYCLES (G),
        .QUEUE_DEPTH(Q)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pulse_in (pulse_in),
        .level_out(level_out),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int cyc,
                       input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic void model_reset();
        st.delete();
        he.delete();
        ac.delete();
        m_ovf = 1'b0;
    endfunction

    function automatic void model_pulse(input int te);
        int last_end;
        int s;
        int cnt;
`ifdef PULSE_STRETCHER_RETRIGGER_EN
        foreach (st[i]) begin
            if (st[i] <= te && te <= he[i]) begin
                int delta;
                delta = te + H - he[i];
                he[i] += delta;
                for (int j = i + 1; j < st.size(); j++) begin
                    st[j] += delta;
                    he[j] += delta;
                end
                return;
            end
        end
`endif
        last_end = -1000;
        if (he.size() != 0) last_end = he[$] + G;
        s = (te + 1 > last_end + 1) ? te + 1 : last_end + 1;
        if (s > te + 1) begin
            cnt = 0;
            foreach (st[i]) if (st[i] > te + 1) cnt++;
            if (cnt >= Q) begin
                m_ovf = 1'b1;
                return;
            end
        end
        st.push_back(s);
        he.push_back(s + H - 1);
        ac.push_back(te);
    endfunction

    function automatic exp_t model_out(input int c);
        exp_t e;
        e.cyc = c;
        e.lvl = 1'b0;
        e.bsy = 1'b0;
        e.pnd = 0;
        e.ovf = m_ovf;
        foreach (st[i]) begin
            if (st[i] <= c && c <= he[i]) e.lvl = 1'b1;
            if (st[i] <= c && c <= he[i] + G) e.bsy = 1'b1;
            if (ac[i] < c && st[i] > c) e.pnd++;
        end
        return e;
    endfunction

    task automatic cycle(input bit p, input bit r);
        if (r) begin
            reset    = 1'b1;
            pulse_in = 1'b0;
            #1;
            chk("async_level", t, int'(level_out), 0);
            chk("async_busy", t, int'(busy), 0);
            chk("async_pending", t, int'(pending), 0);
            chk("async_overflow", t, int'(overflow), 0);
            model_reset();
        end else begin
            reset    = 1'b0;
            pulse_in = p;
            if (p) model_pulse(t);
        end
        exp_q.push_back(model_out(t + 1));
        t++;
        @(negedge clk);
        #2;
    endtask

    task automatic pattern(input logic [15:0] bits, input int len);
        logic [15:0] b;
        b = bits;
        for (int i = 0; i < len; i++) cycle(b[i], 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (run) begin
                if (exp_q.size() == 0) begin
                    chk("scoreboard_empty", t, 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("level_out", e.cyc, int'(level_out), int'(e.lvl));
                    chk("busy", e.cyc, int'(busy), int'(e.bsy));
                    chk("pending", e.cyc, int'(pending), e.pnd);
                    chk("overflow", e.cyc, int'(overflow), int'(e.ovf));
                end
            end
        end
    end

    initial begin : stimulus
        int dens;
        checks   = 0;
        errors   = 0;
        t        = 0;
        run      = 1'b0;
        reset    = 1'b1;
        pulse_in = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("reset_level", 0, int'(level_out), 0);
        chk("reset_busy", 0, int'(busy), 0);
        chk("reset_pending", 0, int'(pending), 0);
        chk("reset_overflow", 0, int'(overflow), 0);
        #1;
        run = 1'b1;

        pattern(16'h0001, 16);
        idle(4);
        pattern(16'h0005, 16);
        idle(4);
        pattern(16'h0041, 16);
        idle(4);
        pattern(16'h0003, 2);
        cycle(1'b1, 1'b0);
        idle(2);
        cycle(1'b0, 1'b1);
        idle(3);
        pattern(16'h003F, 16);
        idle(20);
        pattern(16'h0007, 3);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        pattern(16'h0001, 12);
        pattern(16'hFFFF, 16);
        idle(30);

        dens = 4;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) dens = $urandom_range(1, 12);
            if ($urandom_range(0, 399) == 0) begin
                cycle(1'b0, 1'b1);
            end else begin
                cycle($urandom_range(0, 15) < dens, 1'b0);
            end
        end
        idle(30);

        run = 1'b0;
        if (exp_q.size() != 0) chk("scoreboard_drain", t, exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog cycle %0d: got timeout expected finish", t);
        $fatal(1, "watchdog expired");
    end

endmodule
